// File: rtl/prim_recursion_ctrl_pkg.sv
// Shared definitions for the primitive-recursion controller: FSM state
// encoding and the default operand width.
package prim_recursion_ctrl_pkg;

  localparam int DEFAULT_BW = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_G_WAIT = 2'd1,
    S_H_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/prim_recursion_ctrl_rise_det.sv
// Rising-edge detector: flags a 0->1 transition of d against its value
// registered on the previous clock. Previous-value register clears on reset.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Remember last cycle's level for comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/prim_recursion_ctrl.sv
// Primitive-recursion sequencer: f(x,0)=g(x), f(x,i+1)=h(x,i,f(x,i)).
// All arithmetic lives in the external g/h units; this block only latches
// operands, issues one-cycle launch pulses and collects results.
module prim_recursion_ctrl
  import prim_recursion_ctrl_pkg::*;
#(
  parameter int          BW       = DEFAULT_BW,
  parameter int          NARGS    = 1,
  parameter int unsigned MAX_ITER = 16'hFFFF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ST,
  input  logic                ABORT,
  input  logic [NARGS*BW-1:0] ARGS,
  input  logic [BW-1:0]       N,
  output logic                RD,
  output logic [BW-1:0]       RES,
  output logic                ERR,
  output logic                G_ST,
  output logic                H_ST,
  input  logic                G_RD,
  input  logic                H_RD,
  input  logic [BW-1:0]       G_RES,
  input  logic [BW-1:0]       H_RES,
  output logic [NARGS*BW-1:0] X_OUT,
  output logic [BW-1:0]       H_CNT,
  output logic [BW-1:0]       H_PREV
);

  // Comparison width wide enough for both N and the 32-bit limit.
  localparam int CW = (BW > 32) ? BW : 32;

  logic          st_rise, g_rise, h_rise;
  state_e        state;
  logic [BW-1:0] n_q;
  logic [BW-1:0] cnt;
  logic [BW-1:0] cnt_nxt;
  logic          n_over;

  rise_det u_st_det (.clk(CLK), .rst_n(RST), .d(ST),   .rise(st_rise));
  rise_det u_g_det  (.clk(CLK), .rst_n(RST), .d(G_RD), .rise(g_rise));
  rise_det u_h_det  (.clk(CLK), .rst_n(RST), .d(H_RD), .rise(h_rise));

  // Iteration counter wraps modulo 2^BW.
  assign cnt_nxt = cnt + BW'(1);
  assign n_over  = CW'(N) > CW'(MAX_ITER);

  // Sequencer: launch g once, then h N times, registering every output.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      RD     <= 1'b1;
      RES    <= '0;
      ERR    <= 1'b0;
      G_ST   <= 1'b0;
      H_ST   <= 1'b0;
      H_CNT  <= '0;
      H_PREV <= '0;
      X_OUT  <= '0;
      n_q    <= '0;
      cnt    <= '0;
    end else begin
      // Launch strobes are single-cycle unless re-armed below.
      G_ST <= 1'b0;
      H_ST <= 1'b0;
      case (state)
        S_IDLE: begin
          // ABORT in idle swallows a coincident start request.
          if (st_rise && !ABORT) begin
            if (n_over) begin
              ERR <= 1'b1;
            end else begin
              X_OUT <= ARGS;
              n_q   <= N;
              cnt   <= '0;
              RD    <= 1'b0;
              ERR   <= 1'b0;
              G_ST  <= 1'b1;
              state <= S_G_WAIT;
            end
          end
        end
        S_G_WAIT: begin
          // ABORT takes priority over a same-cycle g completion.
          if (ABORT) begin
            RD    <= 1'b1;
            ERR   <= 1'b1;
            state <= S_IDLE;
          end else if (g_rise) begin
            if (n_q == '0) begin
              RES   <= G_RES;
              RD    <= 1'b1;
              state <= S_IDLE;
            end else begin
              H_CNT  <= '0;
              H_PREV <= G_RES;
              H_ST   <= 1'b1;
              state  <= S_H_WAIT;
            end
          end
        end
        S_H_WAIT: begin
          if (ABORT) begin
            RD    <= 1'b1;
            ERR   <= 1'b1;
            state <= S_IDLE;
          end else if (h_rise) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == n_q) begin
              RES   <= H_RES;
              RD    <= 1'b1;
              state <= S_IDLE;
            end else begin
              // H_PREV carries the running accumulator f(x,i) into h.
              H_CNT  <= cnt_nxt;
              H_PREV <= H_RES;
              H_ST   <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prim_recursion_ctrl.sv
// Directed bench for prim_recursion_ctrl: the bench plays the g/h units and
// checks every output against hand-computed values.
module tb_prim_recursion_ctrl;

  localparam int BW    = 16;
  localparam int NARGS = 1;

  logic                CLK = 1'b0;
  logic                RST, ST, ABORT, G_RD, H_RD;
  logic [NARGS*BW-1:0] ARGS;
  logic [BW-1:0]       N, G_RES, H_RES;
  logic                RD, ERR, G_ST, H_ST;
  logic [BW-1:0]       RES, H_CNT, H_PREV;
  logic [NARGS*BW-1:0] X_OUT;

  int n_cmp = 0;
  int n_bad = 0;
  int gp = 0;
  int hp = 0;

  prim_recursion_ctrl #(.BW(BW), .NARGS(NARGS), .MAX_ITER(8)) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .ABORT(ABORT), .ARGS(ARGS), .N(N),
    .RD(RD), .RES(RES), .ERR(ERR), .G_ST(G_ST), .H_ST(H_ST),
    .G_RD(G_RD), .H_RD(H_RD), .G_RES(G_RES), .H_RES(H_RES),
    .X_OUT(X_OUT), .H_CNT(H_CNT), .H_PREV(H_PREV)
  );

  always #5 CLK = ~CLK;

  // Tally launch-pulse cycles seen by the external units.
  always @(posedge CLK) begin
    if (G_ST) gp <= gp + 1;
    if (H_ST) hp <= hp + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
  endtask

  // One full computation with h(x,i,prev) = x + prev.
  task automatic run_calc(input string tag, input logic [15:0] x, input logic [15:0] n,
                          input logic [15:0] g, input bit poke, input logic [15:0] exp_res);
    logic [15:0] prev;
    int g0, h0;
    g0 = gp; h0 = hp; prev = g;
    ARGS = x; N = n; ST = 1'b1;
    tick;
    ST = 1'b0;
    chk({tag, ":g_st"},  32'(G_ST),  32'(1));
    chk({tag, ":busy"},  32'(RD),    32'(0));
    chk({tag, ":x_out"}, 32'(X_OUT), 32'(x));
    G_RES = g; G_RD = 1'b1;
    tick;
    G_RD = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      chk({tag, ":h_st"},   32'(H_ST),   32'(1));
      chk({tag, ":h_cnt"},  32'(H_CNT),  32'(i));
      chk({tag, ":h_prev"}, 32'(H_PREV), 32'(prev));
      H_RD = 1'b0;
      if (poke && i == 0) begin
        ST = 1'b1; ARGS = 16'h0063; N = 16'd1;
      end
      tick;
      chk({tag, ":h_pulse"}, 32'(H_ST), 32'(0));
      prev = prev + x;
      H_RES = prev; H_RD = 1'b1;
      tick;
    end
    H_RD = 1'b0;
    chk({tag, ":rd"},   32'(RD),  32'(1));
    chk({tag, ":res"},  32'(RES), 32'(exp_res));
    chk({tag, ":err"},  32'(ERR), 32'(0));
    chk({tag, ":g_n"},  32'(gp - g0), 32'(1));
    chk({tag, ":h_n"},  32'(hp - h0), 32'(n));
    ST = 1'b0;
    tick;
  endtask

  initial begin
    int g0, h0;
    bit rd_low;
    RST = 1'b0; ST = 1'b0; ABORT = 1'b0; G_RD = 1'b0; H_RD = 1'b0;
    ARGS = '0; N = '0; G_RES = '0; H_RES = '0;
    tick; tick;
    chk("rst:rd",     32'(RD),     32'(1));
    chk("rst:res",    32'(RES),    32'(0));
    chk("rst:err",    32'(ERR),    32'(0));
    chk("rst:g_st",   32'(G_ST),   32'(0));
    chk("rst:h_st",   32'(H_ST),   32'(0));
    chk("rst:h_cnt",  32'(H_CNT),  32'(0));
    chk("rst:h_prev", 32'(H_PREV), 32'(0));
    chk("rst:x_out",  32'(X_OUT),  32'(0));
    RST = 1'b1;
    tick;

    run_calc("n0",   16'd9,      16'd0, 16'd7, 1'b0, 16'd7);
    run_calc("mul",  16'd5,      16'd3, 16'd0, 1'b1, 16'd15);
    run_calc("wrap", 16'hFFFF,   16'd2, 16'd0, 1'b0, 16'hFFFE);

    // Depth above MAX_ITER is rejected without leaving idle.
    g0 = gp; rd_low = 1'b0;
    ARGS = 16'd1; N = 16'd9; ST = 1'b1;
    repeat (4) begin
      tick;
      ST = 1'b0;
      if (!RD) rd_low = 1'b1;
    end
    chk("rej:err",   32'(ERR),     32'(1));
    chk("rej:rd",    32'(rd_low),  32'(0));
    chk("rej:g_n",   32'(gp - g0), 32'(0));
    chk("rej:res",   32'(RES),     32'(16'hFFFE));

    // Abort on the cycle of the second h completion.
    h0 = hp;
    ARGS = 16'd3; N = 16'd3; ST = 1'b1;
    tick;
    ST = 1'b0;
    chk("ab:err_clr", 32'(ERR), 32'(0));
    G_RES = 16'd1; G_RD = 1'b1;
    tick;
    G_RD = 1'b0;
    tick;
    H_RES = 16'd4; H_RD = 1'b1;
    tick;
    H_RD = 1'b0;
    chk("ab:h_st",  32'(H_ST),  32'(1));
    chk("ab:h_cnt", 32'(H_CNT), 32'(1));
    tick;
    H_RES = 16'd7; H_RD = 1'b1; ABORT = 1'b1;
    tick;
    ABORT = 1'b0; H_RD = 1'b0;
    chk("ab:rd",   32'(RD),   32'(1));
    chk("ab:err",  32'(ERR),  32'(1));
    chk("ab:res",  32'(RES),  32'(16'hFFFE));
    chk("ab:h_st0", 32'(H_ST), 32'(0));
    repeat (3) tick;
    chk("ab:h_n",  32'(hp - h0), 32'(2));

    // ABORT in idle suppresses a coincident start.
    g0 = gp;
    ARGS = 16'd1; N = 16'd1; ABORT = 1'b1; ST = 1'b1;
    tick;
    ABORT = 1'b0; ST = 1'b0;
    chk("iab:rd",   32'(RD),   32'(1));
    chk("iab:g_st", 32'(G_ST), 32'(0));
    tick;
    chk("iab:g_n",  32'(gp - g0), 32'(0));

    // Stray unit-ready edges in idle are ignored.
    g0 = gp; h0 = hp;
    G_RD = 1'b1; H_RD = 1'b1;
    tick;
    G_RD = 1'b0; H_RD = 1'b0;
    tick;
    chk("stray:rd",  32'(RD),      32'(1));
    chk("stray:g_n", 32'(gp - g0), 32'(0));
    chk("stray:h_n", 32'(hp - h0), 32'(0));
    chk("stray:res", 32'(RES),     32'(16'hFFFE));

    // Asynchronous reset while waiting on h.
    ARGS = 16'd2; N = 16'd3; ST = 1'b1;
    tick;
    ST = 1'b0; G_RES = 16'd0; G_RD = 1'b1;
    tick;
    G_RD = 1'b0;
    tick;
    #2 RST = 1'b0;
    #1;
    chk("ar:rd",     32'(RD),     32'(1));
    chk("ar:res",    32'(RES),    32'(0));
    chk("ar:err",    32'(ERR),    32'(0));
    chk("ar:h_cnt",  32'(H_CNT),  32'(0));
    chk("ar:h_prev", 32'(H_PREV), 32'(0));
    chk("ar:x_out",  32'(X_OUT),  32'(0));
    chk("ar:g_st",   32'(G_ST),   32'(0));
    chk("ar:h_st",   32'(H_ST),   32'(0));
    tick;
    g0 = gp; h0 = hp;
    RST = 1'b1; H_RES = 16'd5; H_RD = 1'b1;
    tick;
    H_RD = 1'b0;
    repeat (3) tick;
    chk("ar:g_n", 32'(gp - g0), 32'(0));
    chk("ar:h_n", 32'(hp - h0), 32'(0));
    chk("ar:rd2", 32'(RD),      32'(1));

    run_calc("rcv", 16'd4, 16'd1, 16'd6, 1'b0, 16'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
